// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with mid-bit sampling, framing-error and overrun reporting
// Holds each received byte in received_data until the consumer acknowledges it with data_read.
module uart_receiver #(
    parameter int CLOCKS_PER_BIT = 87
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       serial_in,
    input  logic       data_read,
    output logic [7:0] received_data,
    output logic       data_ready,
    output logic       reception_done,
    output logic       frame_error,
    output logic       overrun,
    output logic       is_receiving
);

    localparam logic [7:0] HALF_CNT = 8'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_CNT = 8'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_CLEANUP
    } state_t;

    logic       sync1_q;
    logic       sync2_q;
    logic       rx;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [2:0] bit_idx_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       ready_q;
    logic       done_q;
    logic       ferr_q;
    logic       ovr_q;
    logic       busy_q;

    // Both flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx = sync2_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            data_q    <= 8'd0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Acknowledge first; a commit later in this block overrides it.
            if (data_read && ready_q) begin
                ready_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q     <= 8'd0;
                    bit_idx_q <= 3'd0;
                    if (!rx) begin
                        state_q <= S_START_BIT;
                        busy_q  <= 1'b1;
                    end
                end

                S_START_BIT: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= 8'd0;
                        if (!rx) begin
                            state_q <= S_DATA_BITS;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_DATA_BITS: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q              <= 8'd0;
                        shift_q[bit_idx_q] <= rx;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP_BIT;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                S_STOP_BIT: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                        state_q <= S_CLEANUP;
                        if (rx) begin
                            data_q  <= shift_q;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            ovr_q   <= ready_q && !data_read;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end

                // A held-low line (break) must not be mistaken for a new start bit.
                S_CLEANUP: begin
                    if (rx) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign received_data  = data_q;
    assign data_ready     = ready_q;
    assign reception_done = done_q;
    assign frame_error    = ferr_q;
    assign overrun        = ovr_q;
    assign is_receiving   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
// Frames are built bit-by-bit from the line protocol; expectations come from a byte-level model.
module tb_uart_receiver;

    localparam int CPB     = 8;
    localparam int HALF    = (CPB - 1) / 2;
    localparam int EXP_LAT = 1 + 2 + HALF + 1 + 9 * CPB;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       serial_in;
    logic       data_read;
    logic [7:0] received_data;
    logic       data_ready;
    logic       reception_done;
    logic       frame_error;
    logic       overrun;
    logic       is_receiving;

    int n_checks = 0;
    int n_pass   = 0;

    int cycle = 0;
    int rd_total = 0;
    int fe_total = 0;
    int ov_total = 0;
    int busy_total = 0;
    int last_rd_cycle = 0;
    logic [7:0] got_q[$];

    logic [7:0] last_good;

    uart_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .serial_in      (serial_in),
        .data_read      (data_read),
        .received_data  (received_data),
        .data_ready     (data_ready),
        .reception_done (reception_done),
        .frame_error    (frame_error),
        .overrun        (overrun),
        .is_receiving   (is_receiving)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    always @(negedge clock) begin
        if (reception_done) begin
            rd_total      = rd_total + 1;
            last_rd_cycle = cycle;
            got_q.push_back(received_data);
        end
        if (frame_error)  fe_total   = fe_total + 1;
        if (overrun)      ov_total   = ov_total + 1;
        if (is_receiving) busy_total = busy_total + 1;
    end

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_read();
        data_read = 1'b1;
        @(negedge clock);
        data_read = 1'b0;
    endtask

    // Called at a negedge; drives start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic do_read);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            if (i == 0 && do_read) begin
                data_read = 1'b1;
                @(negedge clock);
                data_read = 1'b0;
                repeat (CPB - 1) @(negedge clock);
            end else begin
                repeat (CPB) @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (received_data !== 8'h00) $display("FAIL reset_data got %h exp 00", received_data); else n_pass++;
        n_checks++; if (data_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", data_ready); else n_pass++;
        n_checks++; if (reception_done !== 1'b0) $display("FAIL reset_done got %b exp 0", reception_done); else n_pass++;
        n_checks++; if (frame_error !== 1'b0) $display("FAIL reset_ferr got %b exp 0", frame_error); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_ovr got %b exp 0", overrun); else n_pass++;
        n_checks++; if (is_receiving !== 1'b0) $display("FAIL reset_busy got %b exp 0", is_receiving); else n_pass++;
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        int rd0, fe0, ov0, c0;
        logic [7:0] b;
        rd0 = rd_total; fe0 = fe_total; ov0 = ov_total;
        c0 = cycle;
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(3);
        n_checks++; if (rd_total - rd0 !== 1) $display("FAIL basic_done_count got %0d exp 1", rd_total - rd0); else n_pass++;
        n_checks++; if (last_rd_cycle !== c0 + EXP_LAT) $display("FAIL basic_latency got %0d exp %0d", last_rd_cycle - c0, EXP_LAT); else n_pass++;
        b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_checks++; if (b !== 8'hA5) $display("FAIL basic_byte got %h exp a5", b); else n_pass++;
        n_checks++; if (received_data !== 8'hA5) $display("FAIL basic_data got %h exp a5", received_data); else n_pass++;
        n_checks++; if (data_ready !== 1'b1) $display("FAIL basic_ready got %b exp 1", data_ready); else n_pass++;
        n_checks++; if (fe_total - fe0 !== 0 || ov_total - ov0 !== 0) $display("FAIL basic_flags got fe=%0d ov=%0d exp 0 0", fe_total - fe0, ov_total - ov0); else n_pass++;
        pulse_read();
        @(negedge clock);
        n_checks++; if (data_ready !== 1'b0) $display("FAIL basic_ack got %b exp 0", data_ready); else n_pass++;
        last_good = 8'hA5;
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int rd0, fe0, ov0;
        rd0 = rd_total; fe0 = fe_total; ov0 = ov_total;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, 1'b0);
            idle($urandom_range(1, 6));
            pulse_read();
        end
        idle(2);
        n_checks++; if (rd_total - rd0 !== 8) $display("FAIL random_count got %0d exp 8", rd_total - rd0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            n_checks++; if (b !== exp_q[i]) $display("FAIL random_byte%0d got %h exp %h", i, b, exp_q[i]); else n_pass++;
        end
        n_checks++; if (fe_total - fe0 !== 0 || ov_total - ov0 !== 0) $display("FAIL random_flags got fe=%0d ov=%0d exp 0 0", fe_total - fe0, ov_total - ov0); else n_pass++;
        last_good = exp_q[7];
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        int rd0, ov0;
        rd0 = rd_total; ov0 = ov_total;
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(3);
        n_checks++; if (rd_total - rd0 !== 2) $display("FAIL b2b_count got %0d exp 2", rd_total - rd0); else n_pass++;
        b0 = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        b1 = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_checks++; if (b0 !== 8'h00 || b1 !== 8'hFF) $display("FAIL b2b_bytes got %h,%h exp 00,ff", b0, b1); else n_pass++;
        n_checks++; if (ov_total - ov0 !== 0) $display("FAIL b2b_overrun got %0d exp 0", ov_total - ov0); else n_pass++;
        pulse_read();
        last_good = 8'hFF;
    endtask

    task automatic test_overrun();
        int ov0, rd0;
        logic [7:0] b;
        rd0 = rd_total; ov0 = ov_total;
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(2);
        n_checks++; if (ov_total - ov0 !== 0) $display("FAIL ovr_first got %0d exp 0", ov_total - ov0); else n_pass++;
        send_frame(8'hC3, 1'b1, 1'b0);
        idle(2);
        n_checks++; if (ov_total - ov0 !== 1) $display("FAIL ovr_count got %0d exp 1", ov_total - ov0); else n_pass++;
        n_checks++; if (received_data !== 8'hC3) $display("FAIL ovr_data got %h exp c3", received_data); else n_pass++;
        n_checks++; if (data_ready !== 1'b1) $display("FAIL ovr_ready got %b exp 1", data_ready); else n_pass++;
        n_checks++; if (rd_total - rd0 !== 2) $display("FAIL ovr_done_count got %0d exp 2", rd_total - rd0); else n_pass++;
        while (got_q.size() > 0) b = got_q.pop_front();
        pulse_read();
        last_good = 8'hC3;
    endtask

    task automatic test_frame_error();
        int fe0, rd0;
        logic [7:0] b;
        fe0 = fe_total; rd0 = rd_total;
        send_frame(8'h55, 1'b0, 1'b0);
        repeat (20 * CPB) @(negedge clock);
        n_checks++; if (fe_total - fe0 !== 1) $display("FAIL ferr_count got %0d exp 1", fe_total - fe0); else n_pass++;
        n_checks++; if (rd_total - rd0 !== 0) $display("FAIL ferr_done got %0d exp 0", rd_total - rd0); else n_pass++;
        n_checks++; if (received_data !== last_good) $display("FAIL ferr_data got %h exp %h", received_data, last_good); else n_pass++;
        n_checks++; if (data_ready !== 1'b0) $display("FAIL ferr_ready got %b exp 0", data_ready); else n_pass++;
        n_checks++; if (is_receiving !== 1'b0) $display("FAIL break_busy got %b exp 0", is_receiving); else n_pass++;
        idle(2 * CPB);
        n_checks++; if (fe_total - fe0 !== 1 || rd_total - rd0 !== 0) $display("FAIL break_release got fe=%0d rd=%0d exp 1 0", fe_total - fe0, rd_total - rd0); else n_pass++;
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2);
        b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_checks++; if (b !== 8'h81 || data_ready !== 1'b1) $display("FAIL after_break got %h ready=%b exp 81 ready=1", b, data_ready); else n_pass++;
        last_good = 8'h81;
    endtask

    task automatic test_glitch();
        int rd0, fe0, ov0, bz0;
        rd0 = rd_total; fe0 = fe_total; ov0 = ov_total; bz0 = busy_total;
        serial_in = 1'b0;
        repeat (2) @(negedge clock);
        idle(4 * CPB);
        n_checks++; if (busy_total - bz0 <= 0) $display("FAIL glitch_busy_seen got %0d exp >0", busy_total - bz0); else n_pass++;
        n_checks++; if (is_receiving !== 1'b0) $display("FAIL glitch_busy_drop got %b exp 0", is_receiving); else n_pass++;
        n_checks++; if (rd_total - rd0 !== 0 || fe_total - fe0 !== 0 || ov_total - ov0 !== 0) $display("FAIL glitch_flags got rd=%0d fe=%0d ov=%0d exp 0 0 0", rd_total - rd0, fe_total - fe0, ov_total - ov0); else n_pass++;
        n_checks++; if (received_data !== last_good) $display("FAIL glitch_data got %h exp %h", received_data, last_good); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        int rd0;
        fork
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clock);
                reset_n = 1'b0;
                #1;
                n_checks++; if (received_data !== 8'h00 || data_ready !== 1'b0) $display("FAIL midreset_data got %h ready=%b exp 00 ready=0", received_data, data_ready); else n_pass++;
                n_checks++; if (is_receiving !== 1'b0 || reception_done !== 1'b0 || frame_error !== 1'b0 || overrun !== 1'b0) $display("FAIL midreset_flags got busy=%b done=%b fe=%b ov=%b exp 0", is_receiving, reception_done, frame_error, overrun); else n_pass++;
            end
        join
        idle(2);
        reset_n = 1'b1;
        idle(4);
        while (got_q.size() > 0) b = got_q.pop_front();
        rd0 = rd_total;
        send_frame(8'h7E, 1'b1, 1'b0);
        idle(2);
        b = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        n_checks++; if (rd_total - rd0 !== 1 || b !== 8'h7E) $display("FAIL post_reset got %h count=%0d exp 7e count=1", b, rd_total - rd0); else n_pass++;
        n_checks++; if (data_ready !== 1'b1 || received_data !== 8'h7E) $display("FAIL post_reset_out got %h ready=%b exp 7e ready=1", received_data, data_ready); else n_pass++;
    endtask

    initial begin
        reset_n   = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
        last_good = 8'h00;
        @(negedge clock);
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Receives one 8N1 UART frame per transfer: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Samples `serial_in` at mid-bit and validates the start bit.
- Detects framing errors and holds each received byte in an output register until the consumer acknowledges it.
- Sits between the FPGA RX pin and the command decoder. It is the receive-side counterpart of the UART transmitter, sharing its `CLOCKS_PER_BIT` value.

## Interface
- `CLOCKS_PER_BIT`, default 87: clock cycles per UART bit (clock frequency / baud rate). Legal range 4..255; the internal counter is 8 bits.
- `clock`  in  1  system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  UART line, asynchronous to `clock`, idle high.
- `data_read`  in  1  consumer acknowledge; single-cycle pulse or level.
- `received_data`  out  8  last valid byte. Reset 8'h00.
- `data_ready`  out  1  high while `received_data` holds an unread byte. Reset 0.
- `reception_done`  out  1  one-cycle pulse on each valid frame. Reset 0.
- `frame_error`  out  1  one-cycle pulse when the stop bit samples 0. Reset 0.
- `overrun`  out  1  one-cycle pulse when an unread byte is overwritten. Reset 0.
- `is_receiving`  out  1  high from start-bit detection until the frame ends. Reset 0.

## Operation
- Synchronizer: 2-FF synchronizer on `serial_in`; both flops reset to 1. The FSM uses only the synchronized value `rx`.
- Mid-bit sample point: H = (CLOCKS_PER_BIT-1)/2, integer division.
- States: IDLE, START_BIT, DATA_BITS, STOP_BIT, CLEANUP. The FSM resets to IDLE with counter 0 and bit index 0.
- IDLE: clears the counter and bit index.
  - If `rx`=0, go to START_BIT and set `is_receiving`=1.
- START_BIT: the counter increments until it reaches H, then `rx` is checked.
  - `rx`=0: counter is cleared, go to DATA_BITS.
  - `rx`=1: glitch. Go to IDLE, clear `is_receiving`, raise no flags.
- DATA_BITS: the counter runs 0..CLOCKS_PER_BIT-1.
  - At terminal count, `rx` is written into shift[bit_index] and the counter clears.
  - After bit 7, go to STOP_BIT.
- STOP_BIT: at terminal count, `rx` is checked.
  - `rx`=1:
    - `received_data` is loaded from the shift register.
    - `data_ready` is set to 1 and `reception_done` pulses.
    - If `data_ready` was already 1 and `data_read` is low that cycle, `overrun` pulses; the new byte replaces the old one.
  - `rx`=0: `frame_error` pulses. `received_data` and `data_ready` are unchanged.
  - In both cases, clear `is_receiving` and go to CLEANUP.
- CLEANUP:
  - Go to IDLE only when `rx`=1.
  - While `rx`=0 (break condition), stay in CLEANUP. This prevents a false start detection.
- `data_read`:
  - While `data_ready`=1, `data_read` clears `data_ready` on the next edge.
  - If `data_read` is asserted in the same cycle as a new commit, the commit wins: `data_ready` stays 1 and `overrun` does not pulse.
  - `data_read` while `data_ready`=0 is ignored.
- Reset mid-frame: all state and outputs return to reset values immediately. A partial frame is discarded and no flags pulse.

## Timing
- Let A be the first edge at which the synchronizer's first flop captures a start-bit low. The IDLE→START_BIT transition occurs at edge E0 = A+2.
- The start-bit check happens at edge E0+H+1.
- Data bit k (0..7) is sampled at edge E0+H+1+(k+1)·CLOCKS_PER_BIT.
- The stop bit is sampled at edge E0+H+1+9·CLOCKS_PER_BIT. `reception_done` and `frame_error` are high for exactly the cycle after that edge. `data_ready` rises after the same edge.
- With CLOCKS_PER_BIT=87 (H=43):
  - data bit 0 is sampled at E0+131;
  - the stop bit is sampled at E0+827.
- CLEANUP takes at least 1 cycle. With a line already high, a back-to-back frame is accepted with no lost start bit.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Basic frame: CLOCKS_PER_BIT=8; send 0xA5 with an ideal bit period → `received_data`=0xA5, `data_ready`=1, a single `reception_done` pulse; no `frame_error` or `overrun`.
- Back-to-back frames: send 0x00 then 0xFF with no idle gap, pulsing `data_read` after the first → both bytes are received in order; `overrun`=0.
- Overrun: send 0x3C then 0xC3 without `data_read` → `overrun` pulses once at the second stop sample; `received_data`=0xC3; `data_ready` stays 1.
- Framing error and break: send 0x55 with the stop bit 0, then hold the line low for 20 bit periods → `frame_error` pulses once; `received_data` keeps its prior value; the FSM stays in CLEANUP until the line rises; a following 0x81 is received correctly.
- Glitch: pull `serial_in` low for 2 cycles (less than H) → returns to IDLE; no flags; `is_receiving` drops.
- Reset: assert `reset_n`=0 during data bit 4 of a frame → all outputs are 0 immediately; after release, the next 0x7E frame is received correctly.
